// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit and its consumers.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : bubble / nop instruction word
//   EXC_ADEL         : exception code reported for a fetch address error
//   fd_entry_t       : F/D pipeline register contents
//   fetch_addr_err() : fetch address legality check (alignment and IM window)
package fetch_pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [4:0]  EXC_ADEL         = 5'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        exc_adel;
    } fd_entry_t;

    // The upper bound is computed in 33 bits so a window ending at 2^32 still works.
    function automatic logic fetch_addr_err(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned words);
        logic [32:0] limit;
        limit = {1'b0, base} + (33'(words) * 33'd4);
        return (addr[1:0] != 2'b00) | (addr < base) | ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_fd_pipe_reg.sv
// F/D pipeline register.
//   clk_i       : system clock, rising edge
//   reset_i     : synchronous active-high reset, clears the register
//   stall_i     : hold the register contents
//   flush_i     : load a bubble (wins over stall_i)
//   f_pc_i      : PC of the instruction currently being fetched
//   instr_i     : instruction word read at f_pc_i
//   fetch_err_i : f_pc_i is not a legal fetch address
//   d_o         : registered D-stage contents
module fd_pipe_reg
    import fetch_pc_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] f_pc_i,
    input  logic [31:0] instr_i,
    input  logic        fetch_err_i,
    output fd_entry_t   d_o
);

    fd_entry_t d_d, d_q;

    always_comb begin
        d_d = d_q;
        if (flush_i) begin
            // Bubble still carries the F PC so D_PC tracks the fetch stream.
            d_d.pc       = f_pc_i;
            d_d.instr    = NOP_INSTR;
            d_d.valid    = 1'b0;
            d_d.exc_adel = 1'b0;
        end else if (!stall_i) begin
            // A faulting fetch becomes a valid nop tagged with the exception.
            d_d.pc       = f_pc_i;
            d_d.instr    = fetch_err_i ? NOP_INSTR : instr_i;
            d_d.valid    = 1'b1;
            d_d.exc_adel = fetch_err_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign d_o = d_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// F-stage PC register plus F/D pipeline register.
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   npc          : next fetch address, taken verbatim
//   stall        : freeze F_PC and the F/D register
//   flush        : insert a bubble into D (dominates D, stall dominates F_PC)
//   i_inst_addr  : instruction-memory read address (= F_PC)
//   i_inst_rdata : instruction word read combinationally at i_inst_addr
//   F_PC         : current fetch PC
//   D_PC         : PC of the instruction in D
//   D_instr      : instruction in D
//   D_valid      : D holds a real instruction
//   D_exc_adel   : fetch address error for the D instruction
// Optional feature: define FETCH_ADDR_CHECK_EN to flag misaligned or out-of-window
// fetch addresses (window IM_BASE .. IM_BASE + 4*IM_WORDS).
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_exc_adel
);

    logic [31:0] f_pc_d, f_pc_q;
    logic        fetch_err;
    fd_entry_t   d_entry;

    always_comb begin
        f_pc_d = stall ? f_pc_q : npc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q <= RESET_PC;
        end else begin
            f_pc_q <= f_pc_d;
        end
    end

`ifdef FETCH_ADDR_CHECK_EN
    assign fetch_err = fetch_addr_err(f_pc_q, IM_BASE, IM_WORDS);
`else
    logic unused_im_params;
    assign unused_im_params = ^{IM_BASE, 32'(IM_WORDS)};
    assign fetch_err        = 1'b0;
`endif

    fd_pipe_reg u_fd_pipe_reg (
        .clk_i       (clk),
        .reset_i     (reset),
        .stall_i     (stall),
        .flush_i     (flush),
        .f_pc_i      (f_pc_q),
        .instr_i     (i_inst_rdata),
        .fetch_err_i (fetch_err),
        .d_o         (d_entry)
    );

    assign i_inst_addr = f_pc_q;
    assign F_PC        = f_pc_q;
    assign D_PC        = d_entry.pc;
    assign D_instr     = d_entry.instr;
    assign D_valid     = d_entry.valid;
    assign D_exc_adel  = d_entry.exc_adel;

endmodule
